ysyx_23060236_rd_arbiter: RTL and testbench
===========================================

Name: ysyx_23060236_rd_arbiter

Overview:
Two-requester AXI4 read-channel arbiter between the IFU (burst-capable instruction fetch) and the LSU (single-beat loads) and one downstream AXI read slave port. The arbiter grants requesters round-robin and holds each grant until the whole transaction finishes. It counts burst beats and checks them against slave RLAST. A watchdog answers a hung transaction with SLVERR so the core cannot deadlock. It sits between the fetch/load units and the SoC master port.

Parameters:
TIMEOUT, 256, cycles without slave handshake progress before the error response is forced.
CNT_W, 9, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
ifu_araddr  in  32  IFU read address
ifu_arvalid  in  1  IFU AR valid
ifu_arready  out  1  IFU AR ready
ifu_arlen  in  4  IFU burst length minus 1
ifu_arburst  in  2  IFU burst type
ifu_rdata  out  32  IFU read data
ifu_rresp  out  2  IFU read response
ifu_rlast  out  1  IFU last beat
ifu_rvalid  out  1  IFU R valid
ifu_rready  in  1  IFU R ready
lsu_araddr  in  32  LSU read address
lsu_arsize  in  3  LSU access size
lsu_arvalid  in  1  LSU AR valid
lsu_arready  out  1  LSU AR ready
lsu_rdata  out  32  LSU read data
lsu_rresp  out  2  LSU read response
lsu_rvalid  out  1  LSU R valid
lsu_rready  in  1  LSU R ready
s_araddr  out  32  slave address
s_arlen  out  8  slave burst length
s_arsize  out  3  slave size
s_arburst  out  2  slave burst type
s_arvalid  out  1  slave AR valid
s_arready  in  1  slave AR ready
s_rdata  in  32  slave data
s_rresp  in  2  slave response
s_rlast  in  1  slave last
s_rvalid  in  1  slave R valid
s_rready  out  1  slave R ready
timeout_err  out  1  sticky: the watchdog has fired
last_err  out  1  sticky: slave RLAST disagreed with the beat count

Behaviour:
- States: IDLE, ADDR, DATA, ERR. Reset (reset=0, asynchronous) forces IDLE, grant=IFU, last_served=LSU, beat counter=0, watchdog=0, both sticky flags=0.
- All outputs are 0 in IDLE. No request is accepted in the cycle IDLE is entered.
- IDLE: if only one arvalid is high, grant that requester. If both are high, grant the requester that is not last_served. The grant registers and the state moves to ADDR next cycle.
- ADDR: s_ar* are driven from the granted requester. The IFU passes arlen zero-extended and its arburst, with arsize=3'b010. The LSU passes arlen=0, arburst=0 and its own arsize. s_arvalid equals the granted arvalid, and the granted arready equals s_arready. An AR handshake moves to DATA, latches expected_len (IFU arlen, or 0 for the LSU), and clears the beat counter.
- DATA: s_rready equals the granted rready. The granted rvalid, rdata and rresp come from the slave; the other requester sees 0. ifu_rlast is asserted when beat counter == expected_len, independent of s_rlast. On every R handshake the beat counter increments. On the handshake where counter == expected_len, the arbiter sets last_served to the current grant and goes to IDLE. If s_rlast != (counter == expected_len) on any handshake, last_err is set and the transfer still completes by the count.
- Watchdog: counts every cycle in ADDR or DATA and clears on any AR or R handshake. When it reaches TIMEOUT, the state moves to ERR.
- ERR: s_arvalid=0 and s_rready=0. The arbiter gives the granted requester rvalid=1, rresp=2'b10, rdata=0, and ifu_rlast=1 when the IFU holds the grant. This is held until rready, then last_served is updated and the state returns to IDLE. timeout_err is set on entry to ERR.
- A requester dropping arvalid mid-ADDR is an illegal protocol violation. The arbiter keeps the grant and the watchdog eventually recovers.
- Reset asserted mid-transaction aborts to IDLE immediately. Slave-side cleanup is the SoC's responsibility.

Test Plan:
- IFU only, arlen=3, slave returns 4 beats with rlast on the 4th → 4 ifu_rvalid beats, ifu_rlast on beat 4 only, back to IDLE, last_err=0.
- IFU and LSU arvalid in the same cycle after reset (last_served=LSU) → IFU served first, then LSU; repeat both together → LSU then IFU (alternation).
- LSU read of 0x8000_0004 with arsize=2 → s_arlen=0, s_arsize=2, s_arburst=0; lsu_rdata equals slave data; ifu_rvalid stays 0 throughout.
- Slave never asserts s_arready → after TIMEOUT=256 cycles the arbiter enters ERR, lsu_rvalid=1 with rresp=2'b10, timeout_err=1; the next request is served normally.
- IFU arlen=1, slave asserts rlast on beat 1 → last_err=1, ifu_rlast asserted only on beat 2, transaction completes.
- Drop reset low during DATA → all outputs 0 asynchronously, state IDLE, sticky flags cleared.

Source files
------------

// File: rtl/ysyx_23060236_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060236_rd_arbiter
// Brief    : Two-requester AXI4 read-channel arbiter (IFU bursts, LSU single
//            beats) onto one downstream AXI read slave port. Round-robin
//            grant held for the whole transaction, beat counting against
//            slave RLAST, and a watchdog that answers a hung transaction
//            with SLVERR.
// Ports    : clock/reset   - clock, asynchronous active-low reset
//            ifu_*         - IFU AR/R channel (burst capable, provides rlast)
//            lsu_*         - LSU AR/R channel (single beat)
//            s_*           - downstream AXI read slave port
//            timeout_err   - sticky, watchdog has fired
//            last_err      - sticky, slave RLAST disagreed with beat count
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060236_rd_arbiter #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [3:0]  ifu_arlen,
    input  logic [1:0]  ifu_arburst,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,

    output logic [31:0] s_araddr,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rlast,
    input  logic        s_rvalid,
    output logic        s_rready,

    output logic        timeout_err,
    output logic        last_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic             c_gnt_ifu = 1'b0;
    localparam logic             c_gnt_lsu = 1'b1;
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [1:0]       c_slverr  = 2'b10;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_served_q, last_served_d;
    logic [3:0]       beat_q, beat_d;
    logic [3:0]       exp_len_q, exp_len_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             timeout_err_q, timeout_err_d;
    logic             last_err_q, last_err_d;

    logic w_gnt_arvalid;
    logic w_gnt_rready;
    logic w_beat_last;
    logic w_ar_hs;
    logic w_r_hs;

    assign w_gnt_arvalid = (grant_q == c_gnt_lsu) ? lsu_arvalid : ifu_arvalid;
    assign w_gnt_rready  = (grant_q == c_gnt_lsu) ? lsu_rready  : ifu_rready;
    assign w_beat_last   = (beat_q == exp_len_q);
    assign w_ar_hs       = (state_q == ADDR) && w_gnt_arvalid && s_arready;
    assign w_r_hs        = (state_q == DATA) && s_rvalid && w_gnt_rready;

    assign timeout_err = timeout_err_q;
    assign last_err    = last_err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        beat_d        = beat_q;
        exp_len_d     = exp_len_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        last_err_d    = last_err_q;

        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (ifu_arvalid && lsu_arvalid) begin
                    // Contention: the side that was not served last wins.
                    grant_d = (last_served_q == c_gnt_ifu) ? c_gnt_lsu : c_gnt_ifu;
                    state_d = ADDR;
                end else if (ifu_arvalid) begin
                    grant_d = c_gnt_ifu;
                    state_d = ADDR;
                end else if (lsu_arvalid) begin
                    grant_d = c_gnt_lsu;
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (w_ar_hs) begin
                    state_d   = DATA;
                    exp_len_d = (grant_q == c_gnt_lsu) ? 4'd0 : ifu_arlen;
                    beat_d    = 4'd0;
                    wdog_d    = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (wdog_d == c_timeout) begin
                        state_d       = ERR;
                        timeout_err_d = 1'b1;
                    end
                end
            end

            DATA: begin
                if (w_r_hs) begin
                    wdog_d = '0;
                    beat_d = beat_q + 4'd1;
                    // Completion is decided by our own count; a disagreeing
                    // slave RLAST is only recorded.
                    if (s_rlast != w_beat_last) begin
                        last_err_d = 1'b1;
                    end
                    if (w_beat_last) begin
                        last_served_d = grant_q;
                        state_d       = IDLE;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                    if (wdog_d == c_timeout) begin
                        state_d       = ERR;
                        timeout_err_d = 1'b1;
                    end
                end
            end

            ERR: begin
                wdog_d = '0;
                if (w_gnt_rready) begin
                    last_served_d = grant_q;
                    state_d       = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_q       <= c_gnt_ifu;
            last_served_q <= c_gnt_lsu;
            beat_q        <= 4'd0;
            exp_len_q     <= 4'd0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
            last_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            beat_q        <= beat_d;
            exp_len_q     <= exp_len_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
            last_err_q    <= last_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Channel steering, decoded from the registered state and grant
    // ------------------------------------------------------------------
    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = 32'd0;
        ifu_rresp   = 2'b00;
        ifu_rlast   = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = 32'd0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        s_araddr    = 32'd0;
        s_arlen     = 8'd0;
        s_arsize    = 3'b000;
        s_arburst   = 2'b00;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;

        case (state_q)
            ADDR: begin
                s_arvalid = w_gnt_arvalid;
                if (grant_q == c_gnt_lsu) begin
                    s_araddr    = lsu_araddr;
                    s_arsize    = lsu_arsize;
                    lsu_arready = s_arready;
                end else begin
                    s_araddr    = ifu_araddr;
                    s_arlen     = {4'd0, ifu_arlen};
                    s_arsize    = 3'b010;
                    s_arburst   = ifu_arburst;
                    ifu_arready = s_arready;
                end
            end

            DATA: begin
                s_rready = w_gnt_rready;
                if (grant_q == c_gnt_lsu) begin
                    lsu_rvalid = s_rvalid;
                    lsu_rdata  = s_rdata;
                    lsu_rresp  = s_rresp;
                end else begin
                    ifu_rvalid = s_rvalid;
                    ifu_rdata  = s_rdata;
                    ifu_rresp  = s_rresp;
                    ifu_rlast  = w_beat_last;
                end
            end

            ERR: begin
                // Synthesised SLVERR beat; the slave side stays quiet.
                if (grant_q == c_gnt_lsu) begin
                    lsu_rvalid = 1'b1;
                    lsu_rresp  = c_slverr;
                end else begin
                    ifu_rvalid = 1'b1;
                    ifu_rresp  = c_slverr;
                    ifu_rlast  = 1'b1;
                end
            end

            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060236_rd_arbiter
// Brief    : Scoreboard bench for the AXI read arbiter. Directed requests
//            push expected AR and R entries into queues; a monitor pops and
//            compares on every handshake it observes. A behavioural slave
//            returns data = addr + beat*16 + 0x1111_0000.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060236_rd_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [3:0]  ifu_arlen;
    logic [1:0]  ifu_arburst;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rlast;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] lsu_araddr;
    logic [2:0]  lsu_arsize;
    logic        lsu_arvalid;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready;
    logic        timeout_err;
    logic        last_err;

    ysyx_23060236_rd_arbiter #(.TIMEOUT(256), .CNT_W(9)) dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_arlen(ifu_arlen), .ifu_arburst(ifu_arburst), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
        .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .timeout_err(timeout_err), .last_err(last_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          port;   // 0 = IFU, 1 = LSU
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_exp_t;

    r_exp_t  rq[$];
    ar_exp_t aq[$];

    int tests_run = 0;
    int tests_failed = 0;

    bit slv_ar_en = 1'b1;
    bit slv_bad_rlast = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
    endtask

    function automatic void pr(input bit p, input logic [31:0] d, input logic [1:0] r, input logic l);
        r_exp_t e;
        e.port = p; e.data = d; e.resp = r; e.last = l;
        rq.push_back(e);
    endfunction

    function automatic void pa(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
        ar_exp_t e;
        e.addr = a; e.len = l; e.size = s; e.burst = b;
        aq.push_back(e);
    endfunction

    task automatic r_check(input bit port, input logic [31:0] d, input logic [1:0] rs, input logic l);
        r_exp_t e;
        if (rq.size() == 0) begin
            fail_now(port ? "lsu_r_unexpected" : "ifu_r_unexpected");
            return;
        end
        e = rq.pop_front();
        chk("r_port", 32'(port), 32'(e.port));
        chk("r_data", d, e.data);
        chk("r_resp", 32'(rs), 32'(e.resp));
        if (!port) chk("ifu_rlast", 32'(l), 32'(e.last));
    endtask

    // Monitor: every handshake that will complete at the next posedge.
    initial begin
        ar_exp_t a;
        forever begin
            @(negedge clock); #2;
            if (reset) begin
                if (s_arvalid && s_arready) begin
                    if (aq.size() == 0) fail_now("ar_unexpected");
                    else begin
                        a = aq.pop_front();
                        chk("s_araddr", s_araddr, a.addr);
                        chk("s_arlen", 32'(s_arlen), 32'(a.len));
                        chk("s_arsize", 32'(s_arsize), 32'(a.size));
                        chk("s_arburst", 32'(s_arburst), 32'(a.burst));
                    end
                end
                if (ifu_rvalid && ifu_rready) r_check(1'b0, ifu_rdata, ifu_rresp, ifu_rlast);
                if (lsu_rvalid && lsu_rready) r_check(1'b1, lsu_rdata, lsu_rresp, 1'b0);
            end
        end
    end

    // Behavioural AXI read slave.
    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        bit          abort;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0;
        forever begin
            @(negedge clock); #1;
            if (reset && s_arvalid && slv_ar_en) begin
                s_arready = 1'b1;
                a = s_araddr;
                l = s_arlen;
                @(negedge clock); #1;
                s_arready = 1'b0;
                abort = 1'b0;
                for (int b = 0; b <= int'(l) && !abort; b++) begin
                    s_rvalid = 1'b1;
                    s_rdata  = a + 32'(b * 16) + 32'h1111_0000;
                    s_rresp  = 2'b00;
                    s_rlast  = slv_bad_rlast ? (b == 0) : (b == int'(l));
                    while (!s_rready && !abort) begin
                        @(negedge clock); #1;
                        if (!reset) abort = 1'b1;
                    end
                    if (!abort) begin
                        @(negedge clock); #1;
                    end
                end
                s_rvalid = 1'b0;
                s_rlast  = 1'b0;
            end
        end
    end

    task automatic req(input bit port, input logic [31:0] a, input logic [3:0] len, input logic [2:0] size);
        int n;
        n = 0;
        @(negedge clock);
        if (!port) begin
            ifu_araddr = a; ifu_arlen = len; ifu_arburst = 2'b01; ifu_arvalid = 1'b1;
        end else begin
            lsu_araddr = a; lsu_arsize = size; lsu_arvalid = 1'b1;
        end
        forever begin
            #2;
            if (port ? lsu_arready : ifu_arready) break;
            n++;
            if (n > 600) begin
                fail_now("ar_wait_timeout");
                break;
            end
            @(negedge clock);
        end
        @(negedge clock);
        if (!port) ifu_arvalid = 1'b0;
        else lsu_arvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || aq.size() != 0) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 2000) begin
            fail_now("drain_timeout");
            rq.delete();
            aq.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int cnt;
        reset = 0;
        ifu_araddr = 0; ifu_arvalid = 0; ifu_arlen = 0; ifu_arburst = 0; ifu_rready = 1;
        lsu_araddr = 0; lsu_arsize = 0; lsu_arvalid = 0; lsu_rready = 1;

        // Reset state
        repeat (2) @(negedge clock);
        #2;
        chk("rst_s_arvalid", 32'(s_arvalid), 0);
        chk("rst_s_rready", 32'(s_rready), 0);
        chk("rst_s_araddr", s_araddr, 0);
        chk("rst_ifu_rvalid", 32'(ifu_rvalid), 0);
        chk("rst_lsu_rvalid", 32'(lsu_rvalid), 0);
        chk("rst_ifu_arready", 32'(ifu_arready), 0);
        chk("rst_lsu_arready", 32'(lsu_arready), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_last_err", 32'(last_err), 0);
        @(negedge clock);
        reset = 1;
        repeat (2) @(negedge clock);

        // Both together after reset: IFU first (last_served = LSU), then LSU.
        pa(32'h8000_0000, 8'd1, 3'd2, 2'b01);
        pa(32'h8000_0004, 8'd0, 3'd2, 2'b00);
        pr(0, 32'h9111_0000, 2'b00, 1'b0);
        pr(0, 32'h9111_0010, 2'b00, 1'b1);
        pr(1, 32'h9111_0004, 2'b00, 1'b0);
        fork
            req(1'b0, 32'h8000_0000, 4'd1, 3'd0);
            req(1'b1, 32'h8000_0004, 4'd0, 3'd2);
        join
        drain();

        // IFU only, 4-beat burst, rlast on beat 4 only.
        pa(32'h8000_0100, 8'd3, 3'd2, 2'b01);
        pr(0, 32'h9111_0100, 2'b00, 1'b0);
        pr(0, 32'h9111_0110, 2'b00, 1'b0);
        pr(0, 32'h9111_0120, 2'b00, 1'b0);
        pr(0, 32'h9111_0130, 2'b00, 1'b1);
        req(1'b0, 32'h8000_0100, 4'd3, 3'd0);
        drain();
        chk("last_err_clean", 32'(last_err), 0);

        // Both together with last_served = IFU: LSU wins this time.
        pa(32'h8000_0008, 8'd0, 3'd1, 2'b00);
        pa(32'h8000_0200, 8'd0, 3'd2, 2'b01);
        pr(1, 32'h9111_0008, 2'b00, 1'b0);
        pr(0, 32'h9111_0200, 2'b00, 1'b1);
        fork
            req(1'b0, 32'h8000_0200, 4'd0, 3'd0);
            req(1'b1, 32'h8000_0008, 4'd0, 3'd1);
        join
        drain();

        // LSU alone, word read; any IFU beat would mismatch the port.
        pa(32'h8000_0004, 8'd0, 3'd2, 2'b00);
        pr(1, 32'h9111_0004, 2'b00, 1'b0);
        req(1'b1, 32'h8000_0004, 4'd0, 3'd2);
        drain();

        // Slave never accepts AR: watchdog fires after 256 cycles in ADDR.
        slv_ar_en = 1'b0;
        lsu_rready = 1'b0;
        cnt = 0;
        @(negedge clock);
        lsu_araddr = 32'h8000_0040; lsu_arsize = 3'd2; lsu_arvalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock); #2;
            if (s_arvalid) cnt++;
            if (lsu_rvalid) break;
        end
        lsu_arvalid = 1'b0;
        chk("wdog_addr_cycles", 32'(cnt), 32'd256);
        chk("err_lsu_rvalid", 32'(lsu_rvalid), 1);
        chk("err_timeout_err", 32'(timeout_err), 1);
        chk("err_s_arvalid", 32'(s_arvalid), 0);
        repeat (3) @(negedge clock);
        #2;
        chk("err_hold_rvalid", 32'(lsu_rvalid), 1);
        chk("err_hold_ifu_rvalid", 32'(ifu_rvalid), 0);
        pr(1, 32'h0000_0000, 2'b10, 1'b0);
        slv_ar_en = 1'b1;
        @(negedge clock);
        lsu_rready = 1'b1;
        drain();

        // Normal service after the error.
        pa(32'h8000_0044, 8'd0, 3'd2, 2'b00);
        pr(1, 32'h9111_0044, 2'b00, 1'b0);
        req(1'b1, 32'h8000_0044, 4'd0, 3'd2);
        drain();
        chk("timeout_err_sticky", 32'(timeout_err), 1);

        // Slave RLAST early: flagged, completion still by count.
        slv_bad_rlast = 1'b1;
        pa(32'h8000_0300, 8'd1, 3'd2, 2'b01);
        pr(0, 32'h9111_0300, 2'b00, 1'b0);
        pr(0, 32'h9111_0310, 2'b00, 1'b1);
        req(1'b0, 32'h8000_0300, 4'd1, 3'd0);
        drain();
        slv_bad_rlast = 1'b0;
        chk("last_err_set", 32'(last_err), 1);

        // Asynchronous reset in the middle of DATA.
        ifu_rready = 1'b0;
        pa(32'h8000_0400, 8'd3, 3'd2, 2'b01);
        req(1'b0, 32'h8000_0400, 4'd3, 3'd0);
        #2;
        chk("pre_rst_ifu_rvalid", 32'(ifu_rvalid), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_ifu_rvalid", 32'(ifu_rvalid), 0);
        chk("arst_ifu_rlast", 32'(ifu_rlast), 0);
        chk("arst_ifu_rdata", ifu_rdata, 0);
        chk("arst_s_rready", 32'(s_rready), 0);
        chk("arst_timeout_err", 32'(timeout_err), 0);
        chk("arst_last_err", 32'(last_err), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        ifu_rready = 1'b1;
        repeat (2) @(negedge clock);
        chk("post_rst_idle_arvalid", 32'(s_arvalid), 0);

        // last_served back to LSU after reset: IFU wins contention.
        pa(32'h8000_0500, 8'd0, 3'd2, 2'b01);
        pa(32'h8000_050C, 8'd0, 3'd0, 2'b00);
        pr(0, 32'h9111_0500, 2'b00, 1'b1);
        pr(1, 32'h9111_050C, 2'b00, 1'b0);
        fork
            req(1'b0, 32'h8000_0500, 4'd0, 3'd0);
            req(1'b1, 32'h8000_050C, 4'd0, 3'd0);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
